// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter that shares one single-port memory between two
//   requesters: port 0 (processor) and port 1 (loader/debug).
//
//   Each access takes one ACC cycle, in which the memory port is driven, and
//   one RSP cycle, in which the owner's ack pulses. Read data is captured from
//   mem_rdata at the end of ACC and stays valid throughout RSP.
//
// Handshake (req/ack):
//   A requester raises req with we/addr/wdata stable and keeps them stable
//   until it sees ack. ack is a one-cycle pulse in the RSP cycle. An access
//   that has been granted always completes, even if req falls early. During
//   RSP only the other port can be granted, so a port that keeps req high
//   lets a waiting peer in first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/1, we0/1         request and write select per requester
//   addr0/1, wdata0/1     address and write data per requester
//   ack0/1                one-cycle completion pulse per requester
//   rdata0/1              registered read data per requester
//   mem_addr, mem_wdata   memory address / write data (held outside ACC)
//   mem_we                memory write enable, high only in ACC
//   mem_rdata             memory read data for the address driven in ACC
//   busy                  high whenever the FSM is not IDLE
//   owner                 requester being served, or last served when idle
//   dbg_state             current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t state;
   logic   prio;   // requester that wins when both ask
   logic   start;  // an access is granted at this edge
   logic   sel;    // requester granted at this edge

   // Grant decision. In IDLE both ports compete; in RSP the current owner's
   // req is ignored so that a re-request cannot starve the other port.
   always_comb begin
      start = 1'b0;
      sel   = 1'b0;
      case (state)
         IDLE: begin
            start = req0 | req1;
            sel   = (req0 & req1) ? prio : req1;
         end
         RSP: begin
            sel   = ~owner;
            start = owner ? req0 : req1;
         end
         default: begin
            start = 1'b0;
            sel   = 1'b0;
         end
      endcase
   end

   // Memory controls are registers so that an asynchronous reset clears
   // mem_we immediately and aborts a write that is in its ACC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         owner     <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE, RSP: begin
               if (start) begin
                  state     <= ACC;
                  owner     <= sel;
                  mem_addr  <= sel ? addr1  : addr0;
                  mem_wdata <= sel ? wdata1 : wdata0;
                  mem_we    <= sel ? we1    : we0;
               end else begin
                  state <= IDLE;
               end
            end
            ACC: begin
               state  <= RSP;
               mem_we <= 1'b0;
               prio   <= ~owner;
               if (owner) ack1 <= 1'b1;
               else       ack0 <= 1'b1;
               // mem_we still holds the latched direction of this access
               if (!mem_we) begin
                  if (owner) rdata1 <= mem_rdata;
                  else       rdata0 <= mem_rdata;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
